// File: rtl/ifu_axi_pkg.sv
// Shared AXI-style read-channel definitions for the IFU and its instruction memory slave.
package ifu_axi_pkg;

   localparam int unsigned AXI_ADDR_W  = 32;
   localparam int unsigned AXI_DATA_W  = 32;
   localparam int unsigned AXI_RESP_W  = 2;
   localparam int unsigned EXTRA_DLY_W = 4;

   localparam logic [AXI_RESP_W-1:0] RESP_OKAY   = 2'd0;
   localparam logic [AXI_RESP_W-1:0] RESP_SLVERR = 2'd2;
   localparam logic [AXI_RESP_W-1:0] RESP_DECERR = 2'd3;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      RESP
   } rd_state_e;

endpackage

// File: rtl/imem_word_ram.sv
// Word-wide instruction RAM: one synchronous write port, one combinational read port.
// Contents are deliberately not reset so preloaded programs survive a core reset.
module imem_word_ram
   import ifu_axi_pkg::*;
#(
   parameter int unsigned DEPTH_WORDS = 1024,
   parameter int unsigned IDX_W       = $clog2(DEPTH_WORDS)
) (
   input  logic                  clock,
   input  logic                  i_wr_en,
   input  logic [IDX_W-1:0]      i_wr_idx,
   input  logic [AXI_DATA_W-1:0] i_wr_data,
   input  logic [IDX_W-1:0]      i_rd_idx,
   output logic [AXI_DATA_W-1:0] o_rd_data
);

   logic [AXI_DATA_W-1:0] r_mem [DEPTH_WORDS];

   // Preload write; a read in the same cycle still sees the old word.
   always_ff @(posedge clock) begin
      if (i_wr_en) begin
         r_mem[i_wr_idx] <= i_wr_data;
      end
   end

   assign o_rd_data = r_mem[i_rd_idx];

endmodule

// File: rtl/ifu_imem_rd_slave.sv
// Instruction-memory read slave behind the IFU AR queue. One request outstanding at a time;
// response latency is LATENCY plus a per-request extra delay sampled at the AR handshake.
module ifu_imem_rd_slave
   import ifu_axi_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
   parameter int unsigned DEPTH_WORDS = 1024,
   parameter int unsigned LATENCY     = 2
) (
   input  logic                           clock,
   input  logic                           reset,
   output logic                           io_ar_ready,
   input  logic                           io_ar_valid,
   input  logic [AXI_ADDR_W-1:0]          io_ar_bits_addr,
   input  logic [EXTRA_DLY_W-1:0]         io_extra_delay,
   input  logic                           io_r_ready,
   output logic                           io_r_valid,
   output logic [AXI_DATA_W-1:0]          io_r_bits_data,
   output logic [AXI_RESP_W-1:0]          io_r_bits_resp,
   input  logic                           io_wr_en,
   input  logic [$clog2(DEPTH_WORDS)-1:0] io_wr_idx,
   input  logic [AXI_DATA_W-1:0]          io_wr_data
);

   localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
   // Wide enough to hold LATENCY + 15.
   localparam int unsigned CNT_W = $clog2(LATENCY + 16);
   // Bounds kept at 33 bits so BASE_ADDR + size cannot wrap.
   localparam logic [32:0] LO_BOUND = {1'b0, BASE_ADDR};
   localparam logic [32:0] HI_BOUND = {1'b0, BASE_ADDR} + (33'(DEPTH_WORDS) * 33'd4);

   rd_state_e                r_state;
   rd_state_e                w_state_d;
   logic [CNT_W-1:0]         r_cnt;
   logic [CNT_W-1:0]         w_cnt_d;
   logic                     r_ar_ready;
   logic                     r_r_valid;
   logic [AXI_DATA_W-1:0]    r_data;
   logic [AXI_RESP_W-1:0]    r_resp;

   logic                     w_ar_hs;
   logic [CNT_W-1:0]         w_total;
   logic [32:0]              w_addr33;
   logic [AXI_ADDR_W-1:0]    w_offset;
   logic [IDX_W-1:0]         w_rd_idx;
   logic [AXI_DATA_W-1:0]    w_rd_data;
   logic [AXI_DATA_W-1:0]    w_dec_data;
   logic [AXI_RESP_W-1:0]    w_dec_resp;

   assign w_ar_hs  = io_ar_valid & r_ar_ready;
   assign w_total  = CNT_W'(LATENCY) + CNT_W'(io_extra_delay);
   assign w_addr33 = {1'b0, io_ar_bits_addr};
   assign w_offset = io_ar_bits_addr - BASE_ADDR;
   assign w_rd_idx = IDX_W'(w_offset >> 2);

   imem_word_ram #(
      .DEPTH_WORDS (DEPTH_WORDS),
      .IDX_W       (IDX_W)
   ) u_ram (
      .clock     (clock),
      .i_wr_en   (io_wr_en),
      .i_wr_idx  (io_wr_idx),
      .i_wr_data (io_wr_data),
      .i_rd_idx  (w_rd_idx),
      .o_rd_data (w_rd_data)
   );

   // Address decode: misalignment outranks the range check.
   always_comb begin
      w_dec_resp = RESP_OKAY;
      w_dec_data = w_rd_data;
      if (io_ar_bits_addr[1:0] != 2'b00) begin
         w_dec_resp = RESP_SLVERR;
         w_dec_data = '0;
      end else if ((w_addr33 < LO_BOUND) || (w_addr33 >= HI_BOUND)) begin
         w_dec_resp = RESP_DECERR;
         w_dec_data = '0;
      end
   end

   // Next-state and delay counter; counter is preloaded with total-2 so WAIT spans total-1 cycles.
   always_comb begin
      w_state_d = r_state;
      w_cnt_d   = r_cnt;
      unique case (r_state)
         IDLE: begin
            if (w_ar_hs) begin
               if (w_total == CNT_W'(1)) begin
                  w_state_d = RESP;
               end else begin
                  w_state_d = WAIT;
                  w_cnt_d   = w_total - CNT_W'(2);
               end
            end
         end
         WAIT: begin
            if (r_cnt == '0) begin
               w_state_d = RESP;
            end else begin
               w_cnt_d = r_cnt - CNT_W'(1);
            end
         end
         RESP: begin
            if (io_r_ready) begin
               w_state_d = IDLE;
            end
         end
         default: w_state_d = IDLE;
      endcase
   end

   // State, counter and registered handshake flags derived from the next state.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state    <= IDLE;
         r_cnt      <= '0;
         r_ar_ready <= 1'b0;
         r_r_valid  <= 1'b0;
      end else begin
         r_state    <= w_state_d;
         r_cnt      <= w_cnt_d;
         r_ar_ready <= (w_state_d == IDLE);
         r_r_valid  <= (w_state_d == RESP);
      end
   end

   // Response payload is captured at the AR handshake and held until the next one.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_data <= '0;
         r_resp <= RESP_OKAY;
      end else if (w_ar_hs) begin
         r_data <= w_dec_data;
         r_resp <= w_dec_resp;
      end
   end

   assign io_ar_ready    = r_ar_ready;
   assign io_r_valid     = r_r_valid;
   assign io_r_bits_data = r_data;
   assign io_r_bits_resp = r_resp;

endmodule

// File: tb/tb_ifu_imem_rd_slave.sv
// Directed bench for ifu_imem_rd_slave: main instance with LATENCY=2, second with LATENCY=1
// for the back-to-back stream. Inputs are driven and outputs sampled on the falling edge.
module tb_ifu_imem_rd_slave;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        ar_valid, ar_valid1;
   logic [31:0] ar_addr;
   logic [3:0]  extra;
   logic        r_ready, r_ready1;
   logic        wr_en;
   logic [9:0]  wr_idx;
   logic [31:0] wr_data;
   logic        ar_ready, r_valid, ar_ready1, r_valid1;
   logic [31:0] r_data, r_data1;
   logic [1:0]  r_resp, r_resp1;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   ifu_imem_rd_slave #(.BASE_ADDR(32'h8000_0000), .DEPTH_WORDS(1024), .LATENCY(2)) u_dut (
      .clock(clk), .reset(rst_n), .io_ar_ready(ar_ready), .io_ar_valid(ar_valid),
      .io_ar_bits_addr(ar_addr), .io_extra_delay(extra), .io_r_ready(r_ready),
      .io_r_valid(r_valid), .io_r_bits_data(r_data), .io_r_bits_resp(r_resp),
      .io_wr_en(wr_en), .io_wr_idx(wr_idx), .io_wr_data(wr_data)
   );

   ifu_imem_rd_slave #(.BASE_ADDR(32'h8000_0000), .DEPTH_WORDS(1024), .LATENCY(1)) u_dut1 (
      .clock(clk), .reset(rst_n), .io_ar_ready(ar_ready1), .io_ar_valid(ar_valid1),
      .io_ar_bits_addr(ar_addr), .io_extra_delay(4'd0), .io_r_ready(r_ready1),
      .io_r_valid(r_valid1), .io_r_bits_data(r_data1), .io_r_bits_resp(r_resp1),
      .io_wr_en(wr_en), .io_wr_idx(wr_idx), .io_wr_data(wr_data)
   );

   task automatic preload(input logic [9:0] idx, input logic [31:0] data);
      @(negedge clk);
      wr_en = 1'b1; wr_idx = idx; wr_data = data;
      @(negedge clk);
      wr_en = 1'b0;
   endtask

   // Waits (bounded) for ar_ready, issues one request; returns at the falling edge of cycle N+1.
   task automatic send_ar(input logic [31:0] addr, input logic [3:0] ex, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (ar_ready) begin ok = 1'b1; break; end
         @(negedge clk);
      end
      ar_valid = 1'b1; ar_addr = addr; extra = ex;
      @(negedge clk);
      ar_valid = 1'b0;
   endtask

   // Returns k such that r_valid is first seen in cycle N+k, or -1 on timeout.
   task automatic wait_rv(output int k);
      k = -1;
      for (int i = 1; i <= 40; i++) begin
         if (r_valid) begin k = i; break; end
         @(negedge clk);
      end
   endtask

   task automatic test_reset;
      @(negedge clk); @(negedge clk);
      n_vec++; if (ar_ready !== 1'b0) begin n_err++; $display("FAIL rst_ar_ready got %b want 0", ar_ready); end
      n_vec++; if (r_valid !== 1'b0) begin n_err++; $display("FAIL rst_r_valid got %b want 0", r_valid); end
      n_vec++; if (r_data !== 32'h0) begin n_err++; $display("FAIL rst_r_data got %h want 0", r_data); end
      n_vec++; if (r_resp !== 2'd0) begin n_err++; $display("FAIL rst_r_resp got %0d want 0", r_resp); end
      rst_n = 1'b1;
      #1;
      n_vec++; if (ar_ready !== 1'b0) begin n_err++; $display("FAIL rst_rel_ar_ready got %b want 0", ar_ready); end
      @(negedge clk);
      n_vec++; if (ar_ready !== 1'b1) begin n_err++; $display("FAIL rst_first_edge_ar_ready got %b want 1", ar_ready); end
   endtask

   task automatic test_basic;
      bit ok;
      preload(10'd0, 32'h0000_0013);
      send_ar(32'h8000_0000, 4'd0, ok);
      n_vec++; if (ok !== 1'b1) begin n_err++; $display("FAIL basic_accept got %b want 1", ok); end
      n_vec++; if (ar_ready !== 1'b0) begin n_err++; $display("FAIL basic_ar_ready_n1 got %b want 0", ar_ready); end
      n_vec++; if (r_valid !== 1'b0) begin n_err++; $display("FAIL basic_r_valid_n1 got %b want 0", r_valid); end
      @(negedge clk);
      n_vec++; if (r_valid !== 1'b1) begin n_err++; $display("FAIL basic_r_valid_n2 got %b want 1", r_valid); end
      n_vec++; if (r_data !== 32'h0000_0013) begin n_err++; $display("FAIL basic_data got %h want 00000013", r_data); end
      n_vec++; if (r_resp !== 2'd0) begin n_err++; $display("FAIL basic_resp got %0d want 0", r_resp); end
      @(negedge clk);
      n_vec++; if (r_valid !== 1'b0) begin n_err++; $display("FAIL basic_r_valid_n3 got %b want 0", r_valid); end
      n_vec++; if (ar_ready !== 1'b1) begin n_err++; $display("FAIL basic_ar_ready_n3 got %b want 1", ar_ready); end
   endtask

   task automatic test_decode;
      logic [31:0] t_addr [7] = '{32'h8000_0002, 32'h8000_1000, 32'h7FFF_FFFC, 32'h8000_0014,
                                  32'h8000_0FFC, 32'h8000_0FFF, 32'hFFFF_FFFC};
      logic [1:0]  t_resp [7] = '{2'd2, 2'd3, 2'd3, 2'd0, 2'd0, 2'd2, 2'd3};
      logic [31:0] t_data [7] = '{32'h0, 32'h0, 32'h0, 32'h1234_5678, 32'hFEED_F00D, 32'h0, 32'h0};
      bit ok;
      int k;
      preload(10'd5, 32'h1234_5678);
      preload(10'd1023, 32'hFEED_F00D);
      for (int i = 0; i < 7; i++) begin
         send_ar(t_addr[i], 4'd0, ok);
         wait_rv(k);
         n_vec++; if (k !== 2) begin n_err++; $display("FAIL dec%0d_latency got %0d want 2", i, k); end
         n_vec++; if (r_resp !== t_resp[i]) begin n_err++; $display("FAIL dec%0d_resp got %0d want %0d", i, r_resp, t_resp[i]); end
         n_vec++; if (r_data !== t_data[i]) begin n_err++; $display("FAIL dec%0d_data got %h want %h", i, r_data, t_data[i]); end
         @(negedge clk);
      end
   endtask

   task automatic test_backpressure;
      bit ok;
      bit stale;
      int k;
      r_ready = 1'b0;
      send_ar(32'h8000_0000, 4'd5, ok);
      wait_rv(k);
      n_vec++; if (k !== 7) begin n_err++; $display("FAIL bp_latency got %0d want 7", k); end
      for (int i = 0; i < 4; i++) begin
         n_vec++; if (r_valid !== 1'b1) begin n_err++; $display("FAIL bp_stall%0d_valid got %b want 1", i, r_valid); end
         n_vec++; if (r_data !== 32'h13) begin n_err++; $display("FAIL bp_stall%0d_data got %h want 00000013", i, r_data); end
         n_vec++; if (r_resp !== 2'd0) begin n_err++; $display("FAIL bp_stall%0d_resp got %0d want 0", i, r_resp); end
         n_vec++; if (ar_ready !== 1'b0) begin n_err++; $display("FAIL bp_stall%0d_ar_ready got %b want 0", i, ar_ready); end
         ar_valid = 1'b1; ar_addr = 32'h8000_0014;
         @(negedge clk);
      end
      ar_valid = 1'b0; r_ready = 1'b1;
      n_vec++; if (r_data !== 32'h13) begin n_err++; $display("FAIL bp_after_ignored_ar_data got %h want 00000013", r_data); end
      @(negedge clk);
      n_vec++; if (r_valid !== 1'b0) begin n_err++; $display("FAIL bp_post_hs_valid got %b want 0", r_valid); end
      n_vec++; if (ar_ready !== 1'b1) begin n_err++; $display("FAIL bp_post_hs_ar_ready got %b want 1", ar_ready); end
      stale = 1'b0;
      for (int i = 0; i < 6; i++) begin
         if (r_valid) stale = 1'b1;
         @(negedge clk);
      end
      n_vec++; if (stale !== 1'b0) begin n_err++; $display("FAIL bp_ignored_ar_responded got %b want 0", stale); end
   endtask

   task automatic test_same_word_write;
      bit ok;
      int k;
      preload(10'd3, 32'hBBBB_0003);
      for (int i = 0; i < 40 && !ar_ready; i++) @(negedge clk);
      n_vec++; if (ar_ready !== 1'b1) begin n_err++; $display("FAIL sw_ready got %b want 1", ar_ready); end
      ar_valid = 1'b1; ar_addr = 32'h8000_000C; extra = 4'd0;
      wr_en = 1'b1; wr_idx = 10'd3; wr_data = 32'hAAAA_0003;
      @(negedge clk);
      ar_valid = 1'b0; wr_en = 1'b0;
      wait_rv(k);
      n_vec++; if (r_data !== 32'hBBBB_0003) begin n_err++; $display("FAIL sw_old_word got %h want bbbb0003", r_data); end
      @(negedge clk);
      send_ar(32'h8000_000C, 4'd0, ok);
      wr_en = 1'b1; wr_idx = 10'd3; wr_data = 32'hCCCC_0003;
      @(negedge clk);
      wr_en = 1'b0;
      n_vec++; if (r_valid !== 1'b1) begin n_err++; $display("FAIL sw_second_valid got %b want 1", r_valid); end
      n_vec++; if (r_data !== 32'hAAAA_0003) begin n_err++; $display("FAIL sw_new_word got %h want aaaa0003", r_data); end
      @(negedge clk);
      send_ar(32'h8000_000C, 4'd0, ok);
      wait_rv(k);
      n_vec++; if (r_data !== 32'hCCCC_0003) begin n_err++; $display("FAIL sw_late_write got %h want cccc0003", r_data); end
      @(negedge clk);
   endtask

   task automatic test_reset_mid;
      bit ok;
      bit stale;
      int k;
      send_ar(32'h8000_0000, 4'd5, ok);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      n_vec++; if (r_valid !== 1'b0) begin n_err++; $display("FAIL rm_wait_valid got %b want 0", r_valid); end
      n_vec++; if (ar_ready !== 1'b0) begin n_err++; $display("FAIL rm_wait_ar_ready got %b want 0", ar_ready); end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      n_vec++; if (ar_ready !== 1'b1) begin n_err++; $display("FAIL rm_release_ar_ready got %b want 1", ar_ready); end
      stale = 1'b0;
      for (int i = 0; i < 12; i++) begin
         if (r_valid) stale = 1'b1;
         @(negedge clk);
      end
      n_vec++; if (stale !== 1'b0) begin n_err++; $display("FAIL rm_stale_response got %b want 0", stale); end
      send_ar(32'h8000_0000, 4'd0, ok);
      wait_rv(k);
      n_vec++; if (r_data !== 32'h13) begin n_err++; $display("FAIL rm_mem_kept got %h want 00000013", r_data); end
      @(negedge clk);
      r_ready = 1'b0;
      send_ar(32'h8000_0014, 4'd0, ok);
      wait_rv(k);
      n_vec++; if (r_valid !== 1'b1) begin n_err++; $display("FAIL rm_resp_valid got %b want 1", r_valid); end
      rst_n = 1'b0;
      #1;
      n_vec++; if (r_valid !== 1'b0) begin n_err++; $display("FAIL rm_resp_async_drop got %b want 0", r_valid); end
      @(negedge clk);
      rst_n = 1'b1; r_ready = 1'b1;
      @(negedge clk);
      n_vec++; if (ar_ready !== 1'b1) begin n_err++; $display("FAIL rm2_release_ar_ready got %b want 1", ar_ready); end
      n_vec++; if (r_valid !== 1'b0) begin n_err++; $display("FAIL rm2_release_valid got %b want 0", r_valid); end
   endtask

   task automatic test_back_to_back;
      int req = 0;
      int rsp = 0;
      int last_cyc = -1;
      bit overlap = 1'b0;
      logic [31:0] exp;
      for (int i = 0; i < 16; i++) preload(10'(i), 32'hC0DE_0000 + 32'(i * 4));
      for (int cyc = 0; cyc < 200 && rsp < 16; cyc++) begin
         ar_addr   = 32'h8000_0000 + 32'(req * 4);
         ar_valid1 = (req < 16);
         if (ar_ready1 && r_valid1) overlap = 1'b1;
         if (r_valid1) begin
            exp = 32'hC0DE_0000 + 32'(rsp * 4);
            n_vec++; if (r_data1 !== exp) begin n_err++; $display("FAIL b2b%0d_data got %h want %h", rsp, r_data1, exp); end
            n_vec++; if (r_resp1 !== 2'd0) begin n_err++; $display("FAIL b2b%0d_resp got %0d want 0", rsp, r_resp1); end
            rsp++;
            last_cyc = cyc;
         end
         if (ar_ready1 && ar_valid1) req++;
         @(negedge clk);
      end
      ar_valid1 = 1'b0;
      n_vec++; if (rsp !== 16) begin n_err++; $display("FAIL b2b_count got %0d want 16", rsp); end
      n_vec++; if (last_cyc !== 31) begin n_err++; $display("FAIL b2b_last_cycle got %0d want 31", last_cyc); end
      n_vec++; if (overlap !== 1'b0) begin n_err++; $display("FAIL b2b_ready_with_valid got %b want 0", overlap); end
   endtask

   initial begin
      rst_n = 1'b1;
      ar_valid = 1'b0; ar_valid1 = 1'b0; ar_addr = '0; extra = '0;
      r_ready = 1'b1; r_ready1 = 1'b1;
      wr_en = 1'b0; wr_idx = '0; wr_data = '0;
      #2 rst_n = 1'b0;
      test_reset();
      test_basic();
      test_decode();
      test_backpressure();
      test_same_word_write();
      test_reset_mid();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/ifu_imem_rd_slave.md
Name: ifu_imem_rd_slave

Overview:
- Instruction-memory read slave directly downstream of the instruction fetch unit's AR request queue.
- Accepts AXI-style read-address requests (io_ar_*) and returns one 32-bit word per request on a read-data channel (io_r_*).
- Read latency is configurable, plus a per-request extra delay to stress fetch-side backpressure.
- Memory contents are preloaded through a simple write port; serves as the simulation instruction memory for the core.

Parameters:
- BASE_ADDR, 32'h8000_0000, byte address of word 0.
- DEPTH_WORDS, 1024, number of 32-bit words; power of two, at least 2.
- LATENCY, 2, minimum cycles from AR handshake cycle to first io_r_valid cycle; at least 1.

Ports:
- clock  in  1  single clock; all state on rising edge
- reset  in  1  asynchronous, active-low reset (0 = reset asserted)
- io_ar_ready  out  1  slave can accept an address
- io_ar_valid  in  1  address request valid
- io_ar_bits_addr  in  32  byte address
- io_extra_delay  in  4  extra latency cycles, sampled at AR handshake
- io_r_ready  in  1  master accepts data
- io_r_valid  out  1  read data valid
- io_r_bits_data  out  32  read word
- io_r_bits_resp  out  2  0 OKAY, 2 SLVERR, 3 DECERR
- io_wr_en  in  1  preload write enable
- io_wr_idx  in  log2(DEPTH_WORDS)  preload word index
- io_wr_data  in  32  preload word

Behaviour:
- States: IDLE, WAIT, RESP. Exactly one request outstanding at a time.
- Reset (reset=0, asynchronous):
  - state=IDLE; io_ar_ready=0; io_r_valid=0; io_r_bits_data=0; io_r_bits_resp=0; delay counter=0.
  - The memory array is NOT reset; preloaded contents survive.
- io_ar_ready is registered:
  - Rises on the first clock edge after reset deasserts.
  - Equals 1 exactly while state==IDLE.
- AR handshake = io_ar_valid & io_ar_ready, in cycle N. At that edge:
  - Decode the address, read the word, and latch data/resp into the output registers (r_valid still 0).
  - Capture total = LATENCY + io_extra_delay.
  - io_ar_ready drops in cycle N+1.
- Transitions:
  - If total==1: IDLE -> RESP directly.
  - Otherwise: IDLE -> WAIT with counter = total-2; WAIT decrements each cycle; counter==0 -> RESP.
  - io_r_valid is first high in cycle N+total.
- RESP:
  - io_r_valid=1; data and resp held stable until io_r_ready.
  - On the R handshake: -> IDLE; io_r_valid=0 and io_ar_ready=1 in the next cycle.
  - Minimum request-to-request spacing is total+1 cycles.
- io_ar_valid asserted outside IDLE is ignored; no capture occurs.
- Address checks, in priority order:
  - addr[1:0]!=0 -> resp=2 (SLVERR), data=0.
  - addr<BASE_ADDR or addr>=BASE_ADDR+4*DEPTH_WORDS -> resp=3 (DECERR), data=0. Compare at 33 bits so the upper bound does not wrap.
  - Otherwise resp=0, data=mem[(addr-BASE_ADDR)>>2].
- Preload write:
  - Synchronous write, accepted in any state.
  - Write and AR handshake to the same word in the same cycle: the read returns the OLD word.
  - A write after the handshake does not alter latched data.
- Reset mid-operation (WAIT or RESP): io_r_valid drops immediately (asynchronous); the pending response is discarded.

Decomposition:
- Package ifu_axi_pkg:
  - resp constants RESP_OKAY=2'd0, RESP_SLVERR=2'd2, RESP_DECERR=2'd3.
  - state enum {IDLE, WAIT, RESP}.
  - width localparams shared with the IFU.
- One sub-module, imem_word_ram:
  - DEPTH_WORDS x 32 array, one synchronous write port, one read port.
  - No reset on contents.
- FSM, counter and address decode stay in ifu_imem_rd_slave.

Test Plan:
- Reset then preload mem[0]=32'h0000_0013, LATENCY=2, extra=0; AR addr 32'h8000_0000 in cycle N, r_ready=1 -> r_valid high only in cycle N+2, data 32'h0000_0013, resp 0; ar_ready high again in cycle N+3.
- AR addr 32'h8000_0002 -> resp 2, data 0; AR addr 32'h8000_1000 (DEPTH 1024) -> resp 3, data 0; AR addr 32'h7FFF_FFFC -> resp 3.
- extra_delay=5, r_ready held 0 for 4 cycles after r_valid -> r_valid first at N+7, data/resp stable all 4 stall cycles, no new AR accepted, ar_ready=1 one cycle after the R handshake.
- Write mem[3]=A in the same cycle as an AR to 32'h8000_000C with old value B -> returns B; a following AR to the same address returns A.
- Drive reset low while in WAIT -> r_valid and ar_ready 0 immediately; after release, ar_ready=1 next edge, no stale response ever appears, mem contents still readable.
- Back-to-back stream, io_ar_valid held high, addresses 0x8000_0000..0x8000_003C, LATENCY=1 -> 16 responses in order with correct data, ar_ready never high while r_valid high.
